// File: rtl/q_pkg.sv
// Shared types, default widths and helpers for the Q-learning update controller.
package q_pkg;

  localparam int unsigned DATA_WIDTH_DEF   = 16;
  localparam int unsigned STATES_WIDTH_DEF = 4;
  localparam int unsigned N_ACTIONS_DEF    = 4;
  localparam int unsigned ACT_WIDTH_DEF    = 2;
  localparam int unsigned ALPHA_SHIFT_DEF  = 2;
  localparam int unsigned GAMMA_SHIFT_DEF  = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_SCAN,
    S_CALC,
    S_WRITE,
    S_DONE
  } q_state_t;

  // Clamp a wide signed value into the signed range of a dw-bit word.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] x,
                                                   input int unsigned dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/q_update_ctrl_if.sv
// Agent/environment request side and action-RAM bank side of the Q-update controller.
interface q_update_ctrl_if #(
  parameter int unsigned DATA_WIDTH   = q_pkg::DATA_WIDTH_DEF,
  parameter int unsigned STATES_WIDTH = q_pkg::STATES_WIDTH_DEF,
  parameter int unsigned N_ACTIONS    = q_pkg::N_ACTIONS_DEF,
  parameter int unsigned ACT_WIDTH    = q_pkg::ACT_WIDTH_DEF
);
  logic                              start;
  logic [STATES_WIDTH-1:0]           st;
  logic [STATES_WIDTH-1:0]           st_1;
  logic [ACT_WIDTH-1:0]              action;
  logic signed [DATA_WIDTH-1:0]      reward;
  logic                              busy;
  logic                              done;
  logic signed [DATA_WIDTH-1:0]      q_new;
  logic [ACT_WIDTH-1:0]              best_action;
  logic [STATES_WIDTH-1:0]           ram_st;
  logic [STATES_WIDTH-1:0]           ram_st_1;
  logic [N_ACTIONS-1:0]              ram_we;
  logic signed [DATA_WIDTH-1:0]      ram_wdata;
  logic [N_ACTIONS*DATA_WIDTH-1:0]   ram_qt;
  logic [N_ACTIONS*DATA_WIDTH-1:0]   ram_qt_1;

  modport master (
    output start, st, st_1, action, reward, ram_qt, ram_qt_1,
    input  busy, done, q_new, best_action, ram_st, ram_st_1, ram_we, ram_wdata
  );

  modport slave (
    input  start, st, st_1, action, reward, ram_qt, ram_qt_1,
    output busy, done, q_new, best_action, ram_st, ram_st_1, ram_we, ram_wdata
  );
endinterface

// File: rtl/q_max_scan.sv
// Sequential max/argmax over a stream of signed values; ties keep the lowest index.
module q_max_scan #(
  parameter int unsigned DATA_WIDTH = q_pkg::DATA_WIDTH_DEF,
  parameter int unsigned ACT_WIDTH  = q_pkg::ACT_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic                         step,
  input  logic [ACT_WIDTH-1:0]         index,
  input  logic signed [DATA_WIDTH-1:0] data,
  output logic signed [DATA_WIDTH-1:0] max_val,
  output logic [ACT_WIDTH-1:0]         arg
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_val <= '0;
      arg     <= '0;
    end else if (load) begin
      max_val <= data;
      arg     <= '0;
    end else if (step && (data > max_val)) begin
      max_val <= data;
      arg     <= index;
    end
  end

endmodule

// File: rtl/q_update_ctrl.sv
// One Q-learning update per request over a bank of per-action RAMs.
// Optional Q_SATURATE_EN: clamp the new Q-value instead of wrapping it.
module q_update_ctrl
  import q_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned STATES_WIDTH = STATES_WIDTH_DEF,
  parameter int unsigned N_ACTIONS    = N_ACTIONS_DEF,
  parameter int unsigned ACT_WIDTH    = ACT_WIDTH_DEF,
  parameter int unsigned ALPHA_SHIFT  = ALPHA_SHIFT_DEF,
  parameter int unsigned GAMMA_SHIFT  = GAMMA_SHIFT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  q_update_ctrl_if.slave  bus
);

  localparam int unsigned CW = DATA_WIDTH + 2;

  q_state_t                     state;
  q_state_t                     state_nx;
  logic [ACT_WIDTH-1:0]         scan_idx;
  logic [ACT_WIDTH-1:0]         act_q;
  logic signed [DATA_WIDTH-1:0] reward_q;
  logic signed [DATA_WIDTH-1:0] q_sa;
  logic signed [DATA_WIDTH-1:0] scan_data;
  logic signed [DATA_WIDTH-1:0] qsa_sel;
  logic signed [DATA_WIDTH-1:0] max_val;
  logic [ACT_WIDTH-1:0]         arg;
  logic                         accept;
  logic                         scan_last;
  logic                         scan_load;
  logic                         scan_step;
  logic                         busy_d;
  logic                         done_d;
  logic [N_ACTIONS-1:0]         we_d;
  logic signed [CW-1:0]         max_x;
  logic signed [CW-1:0]         gq;
  logic signed [CW-1:0]         tgt;
  logic signed [CW-1:0]         delta;
  logic signed [CW-1:0]         new_w;
  logic signed [DATA_WIDTH-1:0] q_new_c;

  assign accept    = (state == S_IDLE) && bus.start;
  assign scan_last = (scan_idx == ACT_WIDTH'(N_ACTIONS - 1));

  // Read-port selection: next-state row by scan index, current-state row by action.
  always_comb begin
    scan_data = '0;
    qsa_sel   = '0;
    for (int k = 0; k < int'(N_ACTIONS); k++) begin
      if (scan_idx == ACT_WIDTH'(k)) scan_data = bus.ram_qt_1[k*DATA_WIDTH +: DATA_WIDTH];
      if (act_q == ACT_WIDTH'(k))    qsa_sel   = bus.ram_qt[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  q_max_scan #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACT_WIDTH  (ACT_WIDTH)
  ) u_max_scan (
    .clk     (clk),
    .rst     (rst),
    .load    (scan_load),
    .step    (scan_step),
    .index   (scan_idx),
    .data    (scan_data),
    .max_val (max_val),
    .arg     (arg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (bus.start) state_nx = S_READ;
      S_READ:  state_nx = S_SCAN;
      S_SCAN:  if (scan_last) state_nx = S_CALC;
      S_CALC:  state_nx = S_WRITE;
      S_WRITE: state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Next values of the registered control outputs are decoded from the next state.
  always_comb begin
    busy_d    = (state_nx != S_IDLE);
    done_d    = (state_nx == S_DONE);
    we_d      = '0;
    scan_load = 1'b0;
    scan_step = 1'b0;
    if (state_nx == S_WRITE) we_d = N_ACTIONS'(1) << act_q;
    if (state == S_SCAN) begin
      scan_load = (scan_idx == '0);
      scan_step = (scan_idx != '0);
    end
  end

  // Update arithmetic in DATA_WIDTH+2 signed bits.
  always_comb begin
    max_x = CW'(max_val);
    gq    = max_x - (max_x >>> GAMMA_SHIFT);
    tgt   = CW'(reward_q) + gq;
    delta = tgt - CW'(q_sa);
    new_w = CW'(q_sa) + (delta >>> ALPHA_SHIFT);
`ifdef Q_SATURATE_EN
    q_new_c = DATA_WIDTH'(sat_trunc(64'(new_w), DATA_WIDTH));
`else
    q_new_c = new_w[DATA_WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_idx        <= '0;
      act_q           <= '0;
      reward_q        <= '0;
      q_sa            <= '0;
      bus.ram_st      <= '0;
      bus.ram_st_1    <= '0;
      bus.ram_wdata   <= '0;
      bus.q_new       <= '0;
      bus.best_action <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.ram_we      <= '0;
    end else begin
      bus.busy   <= busy_d;
      bus.done   <= done_d;
      bus.ram_we <= we_d;
      if (accept) begin
        act_q        <= bus.action;
        reward_q     <= bus.reward;
        bus.ram_st   <= bus.st;
        bus.ram_st_1 <= bus.st_1;
      end
      if (state == S_READ) scan_idx <= '0;
      if (state == S_SCAN) begin
        scan_idx <= scan_idx + ACT_WIDTH'(1);
        if (scan_idx == '0) q_sa <= qsa_sel;
      end
      if (state == S_CALC) begin
        bus.ram_wdata <= q_new_c;
        bus.q_new     <= q_new_c;
      end
      if (state == S_WRITE) bus.best_action <= arg;
    end
  end

endmodule
